writeback_arbiter: RTL and testbench

//   Multi-source writeback stage: merges NUM_SOURCES producers (ALU, load unit, CSR/mul-div ...) onto one

---
 rtl/writeback_arbiter_if.sv | 38 +++
 rtl/writeback_arbiter.sv | 159 +++++++++++++++
 tb/tb_writeback_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_arbiter_if.sv
// Writeback bus between producer units and the writeback arbiter.
//   master : producer side, drives per-source entries and observes the
//            register-file write, illegal-op event and retire counter.
//   slave  : arbiter side, accepts entries and drives the results.
// Per-source vectors are packed with source 0 in the LSBs.
interface writeback_arbiter_if #(
  parameter int unsigned NUM_SOURCES = 3,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned COUNT_W     = 64
);
  localparam int unsigned SRC_W = $clog2(NUM_SOURCES);

  logic [NUM_SOURCES-1:0]            src_valid;
  logic [NUM_SOURCES-1:0]            src_ready;
  logic [NUM_SOURCES*REG_ADDR_W-1:0] src_dest;
  logic [NUM_SOURCES*XLEN-1:0]       src_data;
  logic [NUM_SOURCES-1:0]            src_wb_enable;
  logic [NUM_SOURCES-1:0]            src_illegal;
  logic                              rf_write_enable;
  logic [REG_ADDR_W-1:0]             rf_write_address;
  logic [XLEN-1:0]                   rf_write_data;
  logic                              illegal_pulse;
  logic [SRC_W-1:0]                  illegal_source;
  logic [COUNT_W-1:0]                retire_count;

  modport master (
    output src_valid, src_dest, src_data, src_wb_enable, src_illegal,
    input  src_ready, rf_write_enable, rf_write_address, rf_write_data,
           illegal_pulse, illegal_source, retire_count
  );

  modport slave (
    input  src_valid, src_dest, src_data, src_wb_enable, src_illegal,
    output src_ready, rf_write_enable, rf_write_address, rf_write_data,
           illegal_pulse, illegal_source, retire_count
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Multi-source writeback stage. Each producer owns a small FIFO; a
// round-robin arbiter drains one entry per cycle onto the single
// register-file write port, counts retired non-illegal entries and flags
// retired illegal entries.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous active-low reset (priority over flush)
//   flush  - synchronous flush: empties FIFOs, drops pushes, cancels pop
//   wb     - writeback_arbiter_if slave: src_* entry inputs / src_ready,
//            registered rf_write_*, illegal_pulse/illegal_source, retire_count
module writeback_arbiter #(
  parameter int unsigned NUM_SOURCES = 3,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned COUNT_W     = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  writeback_arbiter_if.slave wb
);
  localparam int unsigned SRC_W = $clog2(NUM_SOURCES);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] DEPTH_P  = PTR_W'(DEPTH);
  localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NUM_SOURCES - 1);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [XLEN-1:0]       data;
    logic                  wb_enable;
    logic                  illegal;
  } entry_t;

  entry_t               mem_q    [NUM_SOURCES][DEPTH];
  entry_t               mem_d    [NUM_SOURCES][DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q [NUM_SOURCES];
  logic [PTR_W-1:0]     wr_ptr_d [NUM_SOURCES];
  logic [PTR_W-1:0]     rd_ptr_q [NUM_SOURCES];
  logic [PTR_W-1:0]     rd_ptr_d [NUM_SOURCES];
  logic [PTR_W-1:0]     fifo_cnt [NUM_SOURCES];
  logic [NUM_SOURCES-1:0] src_ready;
  logic [NUM_SOURCES-1:0] not_empty;
  logic [NUM_SOURCES-1:0] push;

  logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]     grant, idx;
  logic                 found, pop;
  entry_t               head;

  logic                  rf_write_enable_q,  rf_write_enable_d;
  logic [REG_ADDR_W-1:0] rf_write_address_q, rf_write_address_d;
  logic [XLEN-1:0]       rf_write_data_q,    rf_write_data_d;
  logic                  illegal_pulse_q,    illegal_pulse_d;
  logic [SRC_W-1:0]      illegal_source_q,   illegal_source_d;
  logic [COUNT_W-1:0]    retire_count_q,     retire_count_d;

  // Pointers carry one extra wrap bit so full (count==DEPTH) and empty differ.
  always_comb begin : fifo_status
    for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
      fifo_cnt[i]  = wr_ptr_q[i] - rd_ptr_q[i];
      src_ready[i] = fifo_cnt[i] < DEPTH_P;
      not_empty[i] = fifo_cnt[i] != '0;
      push[i]      = wb.src_valid[i] && src_ready[i];
    end
  end

  // First non-empty source at or after rr_ptr, wrapping modulo NUM_SOURCES.
  always_comb begin : arbiter
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
      idx = SRC_W'((32'(rr_ptr_q) + k) % NUM_SOURCES);
      if (!found && not_empty[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
    pop  = found && !flush;
    head = mem_q[grant][rd_ptr_q[grant][IDX_W-1:0]];
  end

  always_comb begin : fifo_next
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
      if (flush) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
      end else begin
        if (push[i]) begin
          mem_d[i][wr_ptr_q[i][IDX_W-1:0]].dest      = wb.src_dest[i*REG_ADDR_W +: REG_ADDR_W];
          mem_d[i][wr_ptr_q[i][IDX_W-1:0]].data      = wb.src_data[i*XLEN +: XLEN];
          mem_d[i][wr_ptr_q[i][IDX_W-1:0]].wb_enable = wb.src_wb_enable[i];
          mem_d[i][wr_ptr_q[i][IDX_W-1:0]].illegal   = wb.src_illegal[i];
          wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
        end
        if (pop && (grant == SRC_W'(i))) begin
          rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
        end
      end
    end
  end

  always_comb begin : out_next
    rr_ptr_d = rr_ptr_q;
    if (flush) begin
      rr_ptr_d = '0;
    end else if (found) begin
      rr_ptr_d = (grant == LAST_SRC) ? '0 : grant + SRC_W'(1);
    end
    rf_write_enable_d  = pop && head.wb_enable && !head.illegal && (head.dest != '0);
    rf_write_address_d = pop ? head.dest : rf_write_address_q;
    rf_write_data_d    = pop ? head.data : rf_write_data_q;
    illegal_pulse_d    = pop && head.illegal;
    illegal_source_d   = pop ? grant : illegal_source_q;
    retire_count_d     = (pop && !head.illegal) ? retire_count_q + COUNT_W'(1) : retire_count_q;
  end

  always_ff @(posedge clock) begin : state_reg
    if (!reset) begin
      wr_ptr_q           <= '{default: '0};
      rd_ptr_q           <= '{default: '0};
      rr_ptr_q           <= '0;
      rf_write_enable_q  <= 1'b0;
      rf_write_address_q <= '0;
      rf_write_data_q    <= '0;
      illegal_pulse_q    <= 1'b0;
      illegal_source_q   <= '0;
      retire_count_q     <= '0;
    end else begin
      wr_ptr_q           <= wr_ptr_d;
      rd_ptr_q           <= rd_ptr_d;
      rr_ptr_q           <= rr_ptr_d;
      rf_write_enable_q  <= rf_write_enable_d;
      rf_write_address_q <= rf_write_address_d;
      rf_write_data_q    <= rf_write_data_d;
      illegal_pulse_q    <= illegal_pulse_d;
      illegal_source_q   <= illegal_source_d;
      retire_count_q     <= retire_count_d;
    end
  end

  // Storage needs no reset: emptiness is tracked by the pointers alone.
  always_ff @(posedge clock) begin : storage
    mem_q <= mem_d;
  end

  assign wb.src_ready        = src_ready;
  assign wb.rf_write_enable  = rf_write_enable_q;
  assign wb.rf_write_address = rf_write_address_q;
  assign wb.rf_write_data    = rf_write_data_q;
  assign wb.illegal_pulse    = illegal_pulse_q;
  assign wb.illegal_source   = illegal_source_q;
  assign wb.retire_count     = retire_count_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter (3 sources, DEPTH 2, 4-bit retire
// counter so the counter wrap is reachable). Directed stimulus pushes the
// hand-derived retirement sequence into a queue; a negedge monitor pops and
// compares whenever the DUT shows a write, an illegal pulse or a counter step.
module tb_writeback_arbiter;
  logic clock = 1'b0;
  logic reset;
  logic flush;

  always #5 clock = ~clock;

  writeback_arbiter_if #(.NUM_SOURCES(3), .XLEN(32), .REG_ADDR_W(5), .COUNT_W(4)) bus ();

  writeback_arbiter #(
    .NUM_SOURCES(3), .XLEN(32), .REG_ADDR_W(5), .DEPTH(2), .COUNT_W(4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .wb    (bus)
  );

  typedef struct {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
    logic        il;
    logic [1:0]  s;
    logic [3:0]  rc;
  } ev_t;

  ev_t        q[$];
  int         total = 0;
  int         bad   = 0;
  logic [3:0] exp_retire = '0;
  logic [3:0] last_rc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input logic we, input logic [4:0] a, input logic [31:0] d,
                           input logic il, input logic [1:0] s);
    ev_t e;
    if (!il) exp_retire = exp_retire + 4'd1;
    e.we = we; e.a = a; e.d = d; e.il = il; e.s = s; e.rc = exp_retire;
    q.push_back(e);
  endtask

  task automatic set_src(input int unsigned s, input logic v, input logic [4:0] d,
                         input logic [31:0] data, input logic we, input logic il);
    bus.src_valid[s]          = v;
    bus.src_dest[s*5 +: 5]    = d;
    bus.src_data[s*32 +: 32]  = data;
    bus.src_wb_enable[s]      = we;
    bus.src_illegal[s]        = il;
  endtask

  task automatic push1(input int unsigned s, input logic [4:0] d, input logic [31:0] data,
                       input logic we, input logic il);
    set_src(s, 1'b1, d, data, we, il);
    @(posedge clock); #1;
    bus.src_valid = '0;
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 100 && q.size() != 0; n++) @(posedge clock);
    @(posedge clock); #1;
    chk({"drain_", name}, 64'(q.size()), 64'd0);
  endtask

  task automatic flush_idle();
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
  endtask

  task automatic check_zero(input string p);
    chk({p, "_we"},    64'(bus.rf_write_enable),  64'd0);
    chk({p, "_addr"},  64'(bus.rf_write_address), 64'd0);
    chk({p, "_data"},  64'(bus.rf_write_data),    64'd0);
    chk({p, "_pulse"}, 64'(bus.illegal_pulse),    64'd0);
    chk({p, "_src"},   64'(bus.illegal_source),   64'd0);
    chk({p, "_rc"},    64'(bus.retire_count),     64'd0);
    chk({p, "_ready"}, 64'(bus.src_ready),        64'h7);
  endtask

  // Monitor: every pop shows up as a write, an illegal pulse or a counter step.
  always @(negedge clock) begin
    if (!reset) begin
      last_rc = bus.retire_count;
    end else begin
      if (bus.rf_write_enable || bus.illegal_pulse || bus.retire_count != last_rc) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: we=%0b addr=%0d pulse=%0b rc=%0d, expected no event",
                   bus.rf_write_enable, bus.rf_write_address, bus.illegal_pulse, bus.retire_count);
        end else begin
          ev_t e;
          e = q.pop_front();
          chk("ev_we",    64'(bus.rf_write_enable),  64'(e.we));
          chk("ev_addr",  64'(bus.rf_write_address), 64'(e.a));
          chk("ev_data",  64'(bus.rf_write_data),    64'(e.d));
          chk("ev_pulse", 64'(bus.illegal_pulse),    64'(e.il));
          chk("ev_src",   64'(bus.illegal_source),   64'(e.s));
          chk("ev_rc",    64'(bus.retire_count),     64'(e.rc));
        end
      end
      last_rc = bus.retire_count;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned sent[3];
    logic [2:0]  acc;

    reset = 1'b0;
    flush = 1'b0;
    bus.src_valid     = '0;
    bus.src_dest      = '0;
    bus.src_data      = '0;
    bus.src_wb_enable = '0;
    bus.src_illegal   = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check_zero("reset");
    @(posedge clock); #1;

    // Single write from source 1, earliest latency.
    expect_ev(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 2'd1);
    push1(1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0);
    @(negedge clock);
    chk("latency_early_we", 64'(bus.rf_write_enable), 64'd0);
    drain("single");

    // Burst: all sources, 4 entries each, rr starting at 0.
    flush_idle();
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 3; i++)
        expect_ev(1'b1, 5'(1 + i*8 + j), 32'hA000_0000 | 32'(i << 8) | 32'(j), 1'b0, 2'(i));
    sent = '{0, 0, 0};
    for (int cyc = 0; cyc < 60 && (sent[0] < 4 || sent[1] < 4 || sent[2] < 4); cyc++) begin
      for (int i = 0; i < 3; i++)
        set_src(i, sent[i] < 4, 5'(1 + i*8 + int'(sent[i])),
                32'hA000_0000 | 32'(i << 8) | 32'(sent[i]), 1'b1, 1'b0);
      @(negedge clock);
      acc = bus.src_valid & bus.src_ready;
      if (cyc == 2) chk("burst_ready_full", 64'(bus.src_ready), 64'h1);
      @(posedge clock); #1;
      for (int i = 0; i < 3; i++) if (acc[i]) sent[i]++;
    end
    bus.src_valid = '0;
    drain("burst");

    // Non-writing retirements and illegal entries.
    expect_ev(1'b0, 5'd0, 32'h1111_0000, 1'b0, 2'd0);
    push1(0, 5'd0, 32'h1111_0000, 1'b1, 1'b0);
    drain("dest0");
    expect_ev(1'b0, 5'd3, 32'h2222_0000, 1'b0, 2'd1);
    push1(1, 5'd3, 32'h2222_0000, 1'b0, 1'b0);
    drain("nowb");
    expect_ev(1'b0, 5'd9, 32'h3333_0000, 1'b1, 2'd2);
    push1(2, 5'd9, 32'h3333_0000, 1'b1, 1'b1);
    drain("illegal2");
    expect_ev(1'b0, 5'd12, 32'h4444_0000, 1'b1, 2'd1);
    push1(1, 5'd12, 32'h4444_0000, 1'b1, 1'b1);
    drain("illegal1");
    chk("rc_at_max", 64'(bus.retire_count), 64'd15);

    // Flush with FIFOs filling: only the pop before the flush edge retires.
    flush_idle();
    for (int i = 0; i < 3; i++) set_src(i, 1'b1, 5'(20 + i), 32'hF000_0000 + 32'(i), 1'b1, 1'b0);
    expect_ev(1'b1, 5'd20, 32'hF000_0000, 1'b0, 2'd0);
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) set_src(i, 1'b1, 5'(24 + i), 32'hE000_0000 + 32'(i), 1'b1, 1'b0);
    @(posedge clock); #1;
    flush = 1'b1;
    for (int i = 0; i < 3; i++) set_src(i, 1'b1, 5'(28 + i), 32'hD000_0000 + 32'(i), 1'b1, 1'b0);
    @(negedge clock);
    chk("flush_ready_before", 64'(bus.src_ready), 64'h1);
    @(posedge clock); #1;
    flush = 1'b0;
    bus.src_valid = '0;
    @(negedge clock);
    chk("flush_we",    64'(bus.rf_write_enable), 64'd0);
    chk("flush_pulse", 64'(bus.illegal_pulse),   64'd0);
    chk("flush_ready", 64'(bus.src_ready),       64'h7);
    chk("flush_rc",    64'(bus.retire_count),    64'(exp_retire));
    chk("rc_wrap",     64'(bus.retire_count),    64'd0);
    repeat (6) @(posedge clock);
    #1;
    chk("flush_residue", 64'(q.size()), 64'd0);

    // Reset mid-burst (with flush also high) discards everything.
    for (int i = 0; i < 3; i++) set_src(i, 1'b1, 5'(28 + i), 32'hC000_0000 + 32'(i), 1'b1, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    flush = 1'b1;
    @(posedge clock); #1;
    reset = 1'b1;
    flush = 1'b0;
    bus.src_valid = '0;
    exp_retire = '0;
    @(negedge clock);
    check_zero("midreset");
    repeat (6) @(posedge clock);
    #1;
    chk("final_queue_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
